// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram
// Purpose  : Dual-port word RAM with byte-addressed ports and optional wait
//            states. Port A reads and writes with byte enables; port B only
//            reads. Each port has a small IDLE/WAIT/EXEC controller. Every
//            access produces one response strobe WAIT_CYCLES+1 cycles after
//            acceptance. Misaligned or out-of-range addresses return err=1
//            and never write.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            a_req_i/a_we_i/a_addr_i/   - port A request, write flag,
//            a_wdata_i/a_wsel_i           byte address, data, byte enables
//            a_ready_o/a_rvalid_o/      - port A handshake and response
//            a_rdata_o/a_err_o
//            b_req_i/b_addr_i           - port B read request
//            b_ready_o/b_rvalid_o/      - port B handshake and response
//            b_rdata_o/b_err_o
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// dp_ram_ctrl: per-port access sequencer (IDLE -> [WAIT] -> EXEC).
// ----------------------------------------------------------------------------
module dp_ram_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic                  exec,
  output logic [ADDR_WIDTH-1:0] addr_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  // The counter expires on zero, so it loads one less than the wait count.
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       accept;

  // With no wait states the EXEC cycle can overlap the next acceptance,
  // which is what gives one access per cycle.
  assign ready  = (state == S_IDLE) || ((WAIT_CYCLES == 0) && (state == S_EXEC));
  assign exec   = (state == S_EXEC);
  assign accept = req && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_EXEC;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_EXEC;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_EXEC: begin
          // accept can only be true here when WAIT_CYCLES == 0.
          state <= accept ? S_EXEC : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// ----------------------------------------------------------------------------
// dp_ram: top level, storage array and response registers.
// ----------------------------------------------------------------------------
module dp_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Port A: read/write
  input  logic                    a_req_i,
  input  logic                    a_we_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] a_wsel_i,
  output logic                    a_ready_o,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,
  // Port B: read only
  input  logic                    b_req_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  output logic                    b_ready_o,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP   = OFF_W + IDX_W;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

  // Misaligned byte offset, or any address bit above the word index.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return ((a & OFF_MASK) != '0) || ((a >> TOP) != '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_exec, b_exec;
  logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
  logic                  a_we_q;
  logic [DATA_WIDTH-1:0] a_wdata_q;
  logic [BYTES-1:0]      a_wsel_q;
  logic                  a_err, b_err;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  a_wr;
  logic [DATA_WIDTH-1:0] a_word, b_word, b_merged;

  dp_ram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) u_ctrl_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (a_req_i),
    .addr   (a_addr_i),
    .ready  (a_ready_o),
    .exec   (a_exec),
    .addr_q (a_addr_q)
  );

  dp_ram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) u_ctrl_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (b_req_i),
    .addr   (b_addr_i),
    .ready  (b_ready_o),
    .exec   (b_exec),
    .addr_q (b_addr_q)
  );

  // Port A write attributes are captured alongside the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_we_q    <= 1'b0;
      a_wdata_q <= '0;
      a_wsel_q  <= '0;
    end else if (a_req_i && a_ready_o) begin
      a_we_q    <= a_we_i;
      a_wdata_q <= a_wdata_i;
      a_wsel_q  <= a_wsel_i;
    end
  end

  assign a_err  = addr_err(a_addr_q);
  assign b_err  = addr_err(b_addr_q);
  assign a_idx  = a_addr_q[OFF_W +: IDX_W];
  assign b_idx  = b_addr_q[OFF_W +: IDX_W];
  assign a_wr   = a_exec && a_we_q && !a_err;
  assign a_word = mem[a_idx];
  assign b_word = mem[b_idx];

  // Write-first: a port B read of the word port A is writing this cycle
  // sees the enabled new bytes merged over the stored word.
  always_comb begin
    b_merged = b_word;
    if (a_wr && (a_idx == b_idx)) begin
      for (int k = 0; k < BYTES; k++) begin
        if (a_wsel_q[k]) begin
          b_merged[8*k +: 8] = a_wdata_q[8*k +: 8];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain: contents survive
  // rst_n. An aborted access never writes because the controller leaves
  // EXEC asynchronously.
  always_ff @(posedge clk) begin
    if (a_wr) begin
      for (int k = 0; k < BYTES; k++) begin
        if (a_wsel_q[k]) begin
          mem[a_idx][8*k +: 8] <= a_wdata_q[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_o <= 1'b0;
      a_rdata_o  <= '0;
      a_err_o    <= 1'b0;
      b_rvalid_o <= 1'b0;
      b_rdata_o  <= '0;
      b_err_o    <= 1'b0;
    end else begin
      a_rvalid_o <= a_exec;
      a_err_o    <= a_exec && a_err;
      a_rdata_o  <= (a_exec && !a_we_q && !a_err) ? a_word : '0;
      b_rvalid_o <= b_exec;
      b_err_o    <= b_exec && b_err;
      b_rdata_o  <= (b_exec && !b_err) ? b_merged : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_ram
// Purpose  : Self-checking bench for dp_ram. One instance uses no wait
//            states (dut0) and one uses three (dut3). Stimulus pushes the
//            expected responses into per-port queues. Monitors pop and
//            compare them on every response strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ram;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n;

  logic        a0_req, a0_we, a0_ready, a0_rvalid, a0_err;
  logic [31:0] a0_addr, a0_wdata, a0_rdata;
  logic [3:0]  a0_wsel;
  logic        b0_req, b0_ready, b0_rvalid, b0_err;
  logic [31:0] b0_addr, b0_rdata;

  logic        a3_req, a3_we, a3_ready, a3_rvalid, a3_err;
  logic [31:0] a3_addr, a3_wdata, a3_rdata;
  logic [3:0]  a3_wsel;
  logic        b3_req, b3_ready, b3_rvalid, b3_err;
  logic [31:0] b3_addr, b3_rdata;

  dp_ram #(.DATA_WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(0), .ADDR_WIDTH(32)) dut0 (
    .clk(clk), .rst_n(rst0_n),
    .a_req_i(a0_req), .a_we_i(a0_we), .a_addr_i(a0_addr), .a_wdata_i(a0_wdata),
    .a_wsel_i(a0_wsel), .a_ready_o(a0_ready), .a_rvalid_o(a0_rvalid),
    .a_rdata_o(a0_rdata), .a_err_o(a0_err),
    .b_req_i(b0_req), .b_addr_i(b0_addr), .b_ready_o(b0_ready),
    .b_rvalid_o(b0_rvalid), .b_rdata_o(b0_rdata), .b_err_o(b0_err)
  );

  dp_ram #(.DATA_WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(3), .ADDR_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .a_req_i(a3_req), .a_we_i(a3_we), .a_addr_i(a3_addr), .a_wdata_i(a3_wdata),
    .a_wsel_i(a3_wsel), .a_ready_o(a3_ready), .a_rvalid_o(a3_rvalid),
    .a_rdata_o(a3_rdata), .a_err_o(a3_err),
    .b_req_i(b3_req), .b_addr_i(b3_addr), .b_ready_o(b3_ready),
    .b_rvalid_o(b3_rvalid), .b_rdata_o(b3_rdata), .b_err_o(b3_err)
  );

  // Response streams: 0 = dut0 A, 1 = dut0 B, 2 = dut3 A, 3 = dut3 B.
  exp_t  exp_q [4][$];
  string names [4] = '{"A0", "B0", "A3", "B3"};
  int    checks   = 0;
  int    failures = 0;

  task automatic push_exp(input int s, input logic [31:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    exp_q[s].push_back(x);
  endtask

  task automatic check_resp(input int s, input logic [31:0] d, input logic e);
    exp_t x;
    checks++;
    if (exp_q[s].size() == 0) begin
      failures++;
      $display("FAIL %s_resp: unexpected rvalid rdata=%h err=%b, required no response",
               names[s], d, e);
    end else begin
      x = exp_q[s].pop_front();
      if (d !== x.d || e !== x.e) begin
        failures++;
        $display("FAIL %s_resp: rdata=%h err=%b, required rdata=%h err=%b",
                 names[s], d, e, x.d, x.e);
      end
    end
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a0_rvalid === 1'b1) check_resp(0, a0_rdata, a0_err);
    if (b0_rvalid === 1'b1) check_resp(1, b0_rdata, b0_err);
    if (a3_rvalid === 1'b1) check_resp(2, a3_rdata, a3_err);
    if (b3_rvalid === 1'b1) check_resp(3, b3_rdata, b3_err);
  end

  // One cycle of dut0 stimulus on both ports; the request is held until the
  // next call or idle0 changes it.
  task automatic cyc0(input logic ar, input logic aw, input logic [31:0] aa,
                      input logic [31:0] ad, input logic [3:0] as,
                      input logic [31:0] ax, input logic axe,
                      input logic br, input logic [31:0] ba,
                      input logic [31:0] bx, input logic bxe);
    @(negedge clk);
    a0_req = ar; a0_we = aw; a0_addr = aa; a0_wdata = ad; a0_wsel = as;
    b0_req = br; b0_addr = ba;
    if (ar) push_exp(0, ax, axe);
    if (br) push_exp(1, bx, bxe);
    @(posedge clk);
  endtask

  task automatic idle0;
    @(negedge clk);
    a0_req = 1'b0;
    b0_req = 1'b0;
  endtask

  // Single dut3 port A access; waits (bounded) for ready first.
  task automatic iss3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wsel, input logic [31:0] x, input logic xe);
    int n = 0;
    @(negedge clk);
    while (a3_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    expect_eq("iss3_ready", {31'd0, a3_ready}, 32'd1);
    if (a3_ready === 1'b1) begin
      a3_req = 1'b1; a3_we = we; a3_addr = addr; a3_wdata = wdata; a3_wsel = wsel;
      push_exp(2, x, xe);
      @(posedge clk);
      @(negedge clk);
      a3_req = 1'b0;
      a3_we  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    a0_req = 0; a0_we = 0; a0_addr = 0; a0_wdata = 0; a0_wsel = 0; b0_req = 0; b0_addr = 0;
    a3_req = 0; a3_we = 0; a3_addr = 0; a3_wdata = 0; a3_wsel = 0; b3_req = 0; b3_addr = 0;

    // Reset state: ready=1, rvalid=0, err=0, rdata=0 on both ports.
    repeat (3) @(negedge clk);
    expect_eq("rst0_flags", {26'd0, a0_ready, a0_rvalid, a0_err, b0_ready, b0_rvalid, b0_err}, 32'h24);
    expect_eq("rst0_rdata", a0_rdata | b0_rdata, 32'h0);
    expect_eq("rst3_flags", {26'd0, a3_ready, a3_rvalid, a3_err, b3_ready, b3_rvalid, b3_err}, 32'h24);
    expect_eq("rst3_rdata", a3_rdata | b3_rdata, 32'h0);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // ---------------- dut0: no wait states ----------------
    cyc0(1, 1, 32'h0,  32'h01020304, 4'hF, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc0(1, 1, 32'h20, 32'hAAAAAAAA, 4'hF, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    idle0;
    // Read with explicit one-cycle latency check.
    cyc0(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    a0_req = 1'b0;
    expect_eq("lat0_edge0_rvalid", {31'd0, a0_rvalid}, 32'd0);
    @(negedge clk);
    expect_eq("lat0_edge1_rvalid", {31'd0, a0_rvalid}, 32'd1);
    // Byte merge, back-to-back write then read.
    cyc0(1, 1, 32'h10, 32'h00000055, 4'h1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc0(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 0, 0, 32'h0, 32'h0, 0);
    // Same-word collisions: port B sees write-first merged data.
    cyc0(1, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, 1, 32'h20, 32'h12345678, 0);
    cyc0(1, 1, 32'h20, 32'h000000FF, 4'h1, 32'h0, 0, 1, 32'h20, 32'h123456FF, 0);
    cyc0(1, 0, 32'h20, 32'h0, 4'h0, 32'h123456FF, 0, 1, 32'h20, 32'h123456FF, 0);
    // Errors: misaligned on both ports; out-of-range write aliasing word 0
    // must neither write nor merge into the concurrent B read.
    cyc0(1, 0, 32'h2, 32'h0, 4'h0, 32'h0, 1, 1, 32'h3, 32'h0, 1);
    cyc0(1, 1, 32'h00010000, 32'hCAFEF00D, 4'hF, 32'h0, 1, 1, 32'h0, 32'h01020304, 0);
    cyc0(1, 0, 32'h0, 32'h0, 4'h0, 32'h01020304, 0, 0, 32'h0, 32'h0, 0);
    // wsel=0 write is a legal no-op.
    cyc0(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc0(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBE55, 0, 0, 32'h0, 32'h0, 0);
    // Last word in range, then first address past the array.
    cyc0(1, 1, 32'h3FFC, 32'h0BADCAFE, 4'hF, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc0(1, 0, 32'h3FFC, 32'h0, 4'h0, 32'h0BADCAFE, 0, 1, 32'h3FFC, 32'h0BADCAFE, 0);
    cyc0(1, 0, 32'h4000, 32'h0, 4'h0, 32'h0, 1, 1, 32'h4000, 32'h0, 1);
    idle0;

    // ---------------- dut3: three wait states ----------------
    iss3(1, 32'h40, 32'h11111111, 4'hF, 32'h0, 0);
    repeat (8) @(negedge clk);
    expect_eq("tim_ready_idle", {31'd0, a3_ready}, 32'd1);
    a3_req = 1'b1; a3_we = 1'b0; a3_addr = 32'h40;
    push_exp(2, 32'h11111111, 0);
    @(posedge clk);                    // edge 0: accepted
    @(negedge clk);
    a3_addr = 32'h44;                  // request held during wait: must be ignored
    expect_eq("tim_e0_ready_rvalid", {30'd0, a3_ready, a3_rvalid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      expect_eq($sformatf("tim_e%0d_ready_rvalid", k), {30'd0, a3_ready, a3_rvalid}, 32'd0);
    end
    a3_req = 1'b0;
    @(negedge clk);
    expect_eq("tim_e4_ready_rvalid", {30'd0, a3_ready, a3_rvalid}, 32'd3);
    repeat (8) @(negedge clk);

    // Reset during the WAIT phase of a write aborts it.
    expect_eq("abort_ready", {31'd0, a3_ready}, 32'd1);
    a3_req = 1'b1; a3_we = 1'b1; a3_addr = 32'h40; a3_wdata = 32'h99999999; a3_wsel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a3_req = 1'b0; a3_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    expect_eq("abort_flags", {26'd0, a3_ready, a3_rvalid, a3_err, b3_ready, b3_rvalid, b3_err}, 32'h24);
    expect_eq("abort_rdata", a3_rdata | b3_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    repeat (8) @(negedge clk);
    iss3(0, 32'h40, 32'h0, 4'h0, 32'h11111111, 0);
    iss3(0, 32'h41, 32'h0, 4'h0, 32'h0, 1);

    // Every expected response must have been seen.
    repeat (12) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      expect_eq($sformatf("drain_%s_pending", names[s]), exp_q[s].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dp_ram.md
DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 4096, number of words, power of two, minimum 2.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per access, range 0..15.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-005 SHALL have port clk  input  1  the single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port a_req_i  input  1  port A request.
REQ-008 SHALL have port a_we_i  input  1  port A write, 1=write, 0=read.
REQ-009 SHALL have port a_addr_i  input  ADDR_WIDTH  port A byte address.
REQ-010 SHALL have port a_wdata_i  input  DATA_WIDTH  port A write data.
REQ-011 SHALL have port a_wsel_i  input  DATA_WIDTH/8  port A byte enables, bit k = byte k.
REQ-012 SHALL have port a_ready_o  output  1  port A can accept a request.
REQ-013 SHALL have port a_rvalid_o  output  1  port A response strobe, one cycle.
REQ-014 SHALL have port a_rdata_o  output  DATA_WIDTH  port A read data.
REQ-015 SHALL have port a_err_o  output  1  port A error, valid with a_rvalid_o.
REQ-016 SHALL have port b_req_i  input  1  port B read-only request.
REQ-017 SHALL have port b_addr_i  input  ADDR_WIDTH  port B byte address.
REQ-018 SHALL have ports b_ready_o, b_rvalid_o, b_rdata_o, b_err_o: outputs with port A semantics.

Function
REQ-019 Per port: request accepted on a rising edge where req and ready are both 1; address, we, wdata, wsel captured then.
REQ-020 Per port FSM: IDLE (ready=1) -> WAIT (ready=0, counter loads WAIT_CYCLES-1, decrements) -> EXEC; IDLE goes directly to EXEC if WAIT_CYCLES=0.
REQ-021 EXEC cycle: array accessed; response (rvalid=1, rdata, err) registered and asserted the following cycle.
REQ-022 Latency: acceptance edge to rvalid high = WAIT_CYCLES+1 cycles; writes also produce rvalid as acknowledge, rdata=0.
REQ-023 WAIT_CYCLES=0: ready stays 1, one accepted request per cycle per port, back-to-back.
REQ-024 WAIT_CYCLES>0: ready returns to 1 in the cycle rvalid is asserted; throughput 1 per WAIT_CYCLES+1 cycles.
REQ-025 Word index = addr[log2(DATA_WIDTH/8)+log2(DEPTH)-1 : log2(DATA_WIDTH/8)].
REQ-026 Error when address byte-offset bits nonzero or any address bit above the index range set: no write, rdata=0, err=1.
REQ-027 Write updates only bytes with wsel bit set; wsel=0 write is a legal no-op with err=0.
REQ-028 Same-word collision, A write and B read in the same EXEC cycle: B returns the byte-merged new data (write-first).
REQ-029 Port A read returns the array word as of EXEC cycle, including writes completed in earlier cycles.
REQ-030 Ports independent; neither port stalls the other.
REQ-031 req while ready=0 is ignored, not queued.

Reset
REQ-032 rst_n low: FSMs to IDLE, counters 0; ready=1, rvalid=0, rdata=0, err=0 on both ports, asynchronously.
REQ-033 Memory array SHALL NOT be cleared by reset; contents retained.
REQ-034 Reset mid-access aborts the access: no write performed if EXEC not reached; no rvalid after release.

Verification
REQ-035 WAIT_CYCLES=0: A write addr 0x10 data 0xDEADBEEF wsel 0xF, then A read 0x10 -> rvalid next cycle, rdata 0xDEADBEEF, err 0.
REQ-036 Byte merge: word 0x10 = 0xDEADBEEF, write 0x00000055 wsel 0x1 -> read returns 0xDEADBE55.
REQ-037 Collision: same cycle A write 0x20 = 0x12345678 wsel 0xF, B read 0x20 -> b_rdata 0x12345678.
REQ-038 Error: A read 0x0000_0002 -> rvalid, err 1, rdata 0; A write 0x0001_0000 (DEPTH 4096) -> err 1, array unchanged.
REQ-039 WAIT_CYCLES=3: request accepted at edge 0 -> ready 0 edges 1..3, rvalid at edge 4, second req during wait ignored.
REQ-040 Assert rst_n low during WAIT of a write -> all outputs reset immediately; subsequent read of that address returns old data.
